mem_initiator: RTL and testbench

Initiator side of the multicycle CPU's single-port unified memory (8-bit word address, 16-bit data, combinational read, write on rising clock when write enable is high). Accepts instruction-fetch and load/store requests from the CPU control path over two valid/ready channels. Arbitrates between them and runs one memory access at a time. Returns read data on a registered, single-cycle valid pulse.

---
 rtl/mem_pkg.sv | 21 ++
 rtl/mem_initiator.sv | 129 ++++++++++++
 tb/tb_mem_initiator.sv | 223 ++++++++++++++++++++++
 3 files changed

// File: rtl/mem_pkg.sv
// Shared definitions for the memory initiator: default widths, FSM encoding, channel ids.
// Latency: n/a (types and constants only).
// Backpressure: n/a.
package mem_pkg;

  localparam int ADDR_W_DEF = 8;
  localparam int DATA_W_DEF = 16;

  // One access in flight at a time: accept in IDLE, drive memory in ACCESS,
  // pulse the owning channel's valid in RESPOND.
  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    ACCESS  = 2'd1,
    RESPOND = 2'd2
  } state_t;

  // Owner of the access currently held in the holding registers.
  localparam logic CH_FETCH = 1'b0;
  localparam logic CH_DATA  = 1'b1;

endpackage

// File: rtl/mem_initiator.sv
// Arbitrates instruction-fetch and load/store requests onto one single-port memory.
// Latency: request accepted at edge N, memory driven in cycle N, registered valid in cycle N+1.
// Backpressure: both readies low while busy; load/store has fixed priority over fetch in IDLE.
module mem_initiator
  import mem_pkg::*;
#(
  parameter int ADDR_W = ADDR_W_DEF,
  parameter int DATA_W = DATA_W_DEF
) (
  input  logic              clock,
  input  logic              reset,
  input  logic              fetch_req,
  input  logic [ADDR_W-1:0] fetch_addr,
  output logic              fetch_ready,
  output logic              fetch_valid,
  output logic [DATA_W-1:0] fetch_data,
  input  logic              data_req,
  input  logic              data_we,
  input  logic [ADDR_W-1:0] data_addr,
  input  logic [DATA_W-1:0] data_wdata,
  output logic              data_ready,
  output logic              data_valid,
  output logic [DATA_W-1:0] data_rdata,
  output logic [ADDR_W-1:0] mem_address,
  output logic              mem_write_enable,
  output logic [DATA_W-1:0] mem_wdata,
  input  logic [DATA_W-1:0] mem_rdata,
  output logic              busy
);

  state_t            state;
  state_t            state_nxt;
  logic [ADDR_W-1:0] hold_addr;
  logic              hold_we;
  logic [DATA_W-1:0] hold_wdata;
  logic              hold_ch;
  logic              accept_data;
  logic              accept_fetch;
  logic              in_access;

  assign in_access = (state == ACCESS);

  // The holding registers keep the last access, so the memory bus shows the
  // held address/data outside ACCESS as well.
  assign mem_address = hold_addr;
  assign mem_wdata   = hold_wdata;

  // State register; reset drops straight to IDLE, which kills any write enable at once.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state <= IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  // Next-state, arbitration and combinational handshake / memory-strobe outputs.
  always_comb begin
    state_nxt        = state;
    busy             = 1'b1;
    data_ready       = 1'b0;
    fetch_ready      = 1'b0;
    accept_data      = 1'b0;
    accept_fetch     = 1'b0;
    mem_write_enable = 1'b0;
    case (state)
      IDLE: begin
        busy         = 1'b0;
        data_ready   = 1'b1;
        fetch_ready  = ~data_req;
        accept_data  = data_req;
        accept_fetch = fetch_req & ~data_req;
        if (data_req || fetch_req) begin
          state_nxt = ACCESS;
        end
      end
      ACCESS: begin
        // Only a data-channel store may write; the fetch path never sets hold_we.
        mem_write_enable = hold_we & (hold_ch == CH_DATA);
        state_nxt        = RESPOND;
      end
      RESPOND: begin
        state_nxt = IDLE;
      end
      default: begin
        state_nxt = IDLE;
      end
    endcase
  end

  // Latch the winning request; fetch leaves the write-data register untouched.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      hold_addr  <= '0;
      hold_we    <= 1'b0;
      hold_wdata <= '0;
      hold_ch    <= CH_FETCH;
    end else if (accept_data) begin
      hold_addr  <= data_addr;
      hold_we    <= data_we;
      hold_wdata <= data_wdata;
      hold_ch    <= CH_DATA;
    end else if (accept_fetch) begin
      hold_addr  <= fetch_addr;
      hold_we    <= 1'b0;
      hold_ch    <= CH_FETCH;
    end
  end

  // Capture read data at the end of ACCESS and raise the owner's one-cycle valid.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      fetch_valid <= 1'b0;
      data_valid  <= 1'b0;
      fetch_data  <= '0;
      data_rdata  <= '0;
    end else begin
      fetch_valid <= in_access && (hold_ch == CH_FETCH);
      data_valid  <= in_access && (hold_ch == CH_DATA);
      if (in_access && (hold_ch == CH_FETCH)) begin
        fetch_data <= mem_rdata;
      end
      if (in_access && (hold_ch == CH_DATA) && !hold_we) begin
        data_rdata <= mem_rdata;
      end
    end
  end

endmodule

// File: tb/tb_mem_initiator.sv
// Self-checking bench for mem_initiator against a transaction-level reference model.
// Latency: model expects memory activity one cycle after acceptance, valid one cycle later.
// Backpressure: requesters hold their pending request until accepted; may toggle req while busy.
module tb_mem_initiator;

  localparam int AW = 8;
  localparam int DW = 16;

  logic          clock = 1'b0;
  logic          reset;
  logic          fetch_req;
  logic [AW-1:0] fetch_addr;
  logic          fetch_ready;
  logic          fetch_valid;
  logic [DW-1:0] fetch_data;
  logic          data_req;
  logic          data_we;
  logic [AW-1:0] data_addr;
  logic [DW-1:0] data_wdata;
  logic          data_ready;
  logic          data_valid;
  logic [DW-1:0] data_rdata;
  logic [AW-1:0] mem_address;
  logic          mem_write_enable;
  logic [DW-1:0] mem_wdata;
  logic [DW-1:0] mem_rdata;
  logic          busy;

  mem_initiator #(.ADDR_W(AW), .DATA_W(DW)) dut (
    .clock(clock), .reset(reset),
    .fetch_req(fetch_req), .fetch_addr(fetch_addr), .fetch_ready(fetch_ready),
    .fetch_valid(fetch_valid), .fetch_data(fetch_data),
    .data_req(data_req), .data_we(data_we), .data_addr(data_addr),
    .data_wdata(data_wdata), .data_ready(data_ready), .data_valid(data_valid),
    .data_rdata(data_rdata),
    .mem_address(mem_address), .mem_write_enable(mem_write_enable),
    .mem_wdata(mem_wdata), .mem_rdata(mem_rdata), .busy(busy)
  );

  always #5 clock = ~clock;

  // Memory attached to the DUT: combinational read, write on rising edge.
  logic [DW-1:0] mem [0:255];
  assign mem_rdata = mem[mem_address];

  initial begin
    for (int i = 0; i < 256; i++) mem[i] = DW'($urandom);
    mem[8'h05] = 16'h6600;
    forever begin
      @(posedge clock);
      if (mem_write_enable) mem[mem_address] <= mem_wdata;
    end
  end

  int cyc = 0;
  always @(posedge clock) cyc <= cyc + 1;

  int total = 0;
  int bad   = 0;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got=%0h want=%0h (cycle %0d)", tag, got, exp, cyc);
    end
  endtask

  // Reference model: what the memory should hold and which transaction is in flight.
  logic [DW-1:0] ref_mem [0:255];
  int            acc_n = -10;   // edge at which the last request was accepted
  logic          acc_ch;        // 1 = data channel
  logic          acc_we;
  logic [AW-1:0] acc_addr;
  logic [DW-1:0] acc_wdata;
  logic [AW-1:0] exp_addr;
  logic [DW-1:0] exp_fdata;
  logic [DW-1:0] exp_drdata;

  // Requester state.
  logic          f_pend, d_pend, d_we_r;
  logic [AW-1:0] f_addr, d_addr_r;
  logic [DW-1:0] d_wdata_r;
  int            f_rate, d_rate;
  logic          toggle;

  task automatic model_reset();
    acc_n = -10; acc_ch = 1'b0; acc_we = 1'b0; acc_addr = '0; acc_wdata = '0;
    exp_addr = '0; exp_fdata = '0; exp_drdata = '0;
    f_pend = 1'b0; d_pend = 1'b0;
  endtask

  // One cycle: check outputs against the model, drive new requests, check readies, record acceptance.
  task automatic step();
    bit idle;
    @(negedge clock);
    idle = (cyc >= acc_n + 2);
    if (cyc == acc_n + 1) begin
      if (acc_ch && acc_we) ref_mem[acc_addr] = acc_wdata;
      else if (acc_ch)      exp_drdata = ref_mem[acc_addr];
      else                  exp_fdata  = ref_mem[acc_addr];
    end
    chk("busy", 32'(busy), 32'(!idle));
    chk("fetch_valid", 32'(fetch_valid), 32'((cyc == acc_n + 1) && !acc_ch));
    chk("data_valid", 32'(data_valid), 32'((cyc == acc_n + 1) && acc_ch));
    chk("fetch_data", 32'(fetch_data), 32'(exp_fdata));
    chk("data_rdata", 32'(data_rdata), 32'(exp_drdata));
    chk("mem_we", 32'(mem_write_enable), 32'((cyc == acc_n) && acc_ch && acc_we));
    chk("mem_address", 32'(mem_address), 32'(exp_addr));
    if ((cyc == acc_n) && acc_ch && acc_we) chk("mem_wdata", 32'(mem_wdata), 32'(acc_wdata));

    if (!f_pend && ($urandom_range(99) < f_rate)) begin
      f_pend = 1'b1; f_addr = AW'($urandom);
    end
    if (!d_pend && ($urandom_range(99) < d_rate)) begin
      d_pend = 1'b1; d_we_r = 1'($urandom); d_addr_r = AW'($urandom); d_wdata_r = DW'($urandom);
    end
    fetch_req  = (!idle && toggle) ? 1'($urandom) : f_pend;
    data_req   = (!idle && toggle) ? 1'($urandom) : d_pend;
    fetch_addr = f_addr;
    data_we    = d_we_r;
    data_addr  = d_addr_r;
    data_wdata = d_wdata_r;
    #1;
    chk("data_ready", 32'(data_ready), 32'(idle));
    chk("fetch_ready", 32'(fetch_ready), 32'(idle && !data_req));
    if (idle && data_req) begin
      acc_n = cyc + 1; acc_ch = 1'b1; acc_we = d_we_r; acc_addr = d_addr_r;
      acc_wdata = d_wdata_r; exp_addr = d_addr_r; d_pend = 1'b0;
    end else if (idle && fetch_req) begin
      acc_n = cyc + 1; acc_ch = 1'b0; acc_we = 1'b0; acc_addr = f_addr;
      exp_addr = f_addr; f_pend = 1'b0;
    end
  endtask

  initial begin
    logic [DW-1:0] before10;
    reset = 1'b1;
    fetch_req = 1'b0; fetch_addr = '0;
    data_req = 1'b0; data_we = 1'b0; data_addr = '0; data_wdata = '0;
    f_addr = '0; d_addr_r = '0; d_we_r = 1'b0; d_wdata_r = '0;
    f_rate = 0; d_rate = 0; toggle = 1'b0;
    model_reset();
    #1;
    chk("rst_fetch_ready", 32'(fetch_ready), 32'd1);
    chk("rst_data_ready", 32'(data_ready), 32'd1);
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_mem_we", 32'(mem_write_enable), 32'd0);
    chk("rst_mem_address", 32'(mem_address), 32'd0);
    chk("rst_mem_wdata", 32'(mem_wdata), 32'd0);
    chk("rst_valids", 32'({fetch_valid, data_valid}), 32'd0);
    chk("rst_data_out", 32'({fetch_data, data_rdata}), 32'd0);
    repeat (2) @(posedge clock);
    @(negedge clock);
    for (int i = 0; i < 256; i++) ref_mem[i] = mem[i];
    reset = 1'b0;

    // Single fetch from 0x05.
    f_pend = 1'b1; f_addr = 8'h05;
    repeat (4) step();
    chk("fetch_6600", 32'(fetch_data), 32'h6600);

    // Store 0xA5A5 to 0x3F, then load it back.
    d_pend = 1'b1; d_we_r = 1'b1; d_addr_r = 8'h3F; d_wdata_r = 16'hA5A5;
    repeat (4) step();
    d_pend = 1'b1; d_we_r = 1'b0; d_addr_r = 8'h3F;
    repeat (4) step();
    chk("load_a5a5", 32'(data_rdata), 32'hA5A5);

    // Contention: load 0x07 and fetch 0x02 raised together.
    f_pend = 1'b1; f_addr = 8'h02;
    d_pend = 1'b1; d_we_r = 1'b0; d_addr_r = 8'h07;
    repeat (8) step();

    // Back-to-back: both channels always requesting.
    f_rate = 100; d_rate = 100;
    repeat (60) step();

    // Requests toggling while busy, then mixed random traffic.
    toggle = 1'b1; f_rate = 60; d_rate = 30;
    repeat (300) step();
    f_rate = 40; d_rate = 50;
    repeat (1500) step();

    // Drain everything pending.
    toggle = 1'b0; f_rate = 0; d_rate = 0;
    repeat (10) step();

    // Reset asserted during the ACCESS cycle of a store to 0x10.
    before10 = ref_mem[8'h10];
    d_pend = 1'b1; d_we_r = 1'b1; d_addr_r = 8'h10; d_wdata_r = 16'h1234;
    step();
    step();
    #2 reset = 1'b1;
    #1;
    chk("abort_mem_we", 32'(mem_write_enable), 32'd0);
    chk("abort_busy", 32'(busy), 32'd0);
    chk("abort_valids", 32'({fetch_valid, data_valid}), 32'd0);
    chk("abort_data_out", 32'({fetch_data, data_rdata}), 32'd0);
    chk("abort_mem_address", 32'(mem_address), 32'd0);
    chk("abort_mem_wdata", 32'(mem_wdata), 32'd0);
    @(posedge clock);
    @(negedge clock);
    reset = 1'b0;
    model_reset();
    #1;
    chk("abort_mem10", 32'(mem[8'h10]), 32'(before10));
    chk("abort_fetch_ready", 32'(fetch_ready), 32'd1);
    chk("abort_data_ready", 32'(data_ready), 32'd1);

    // Traffic after the aborted access.
    f_rate = 50; d_rate = 50; toggle = 1'b1;
    repeat (200) step();
    toggle = 1'b0; f_rate = 0; d_rate = 0;
    repeat (10) step();

    for (int i = 0; i < 256; i++) chk("mem_image", 32'(mem[i]), 32'(ref_mem[i]));

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
